bless_inject: RTL and testbench
===============================

Name: bless_inject

Overview:
- Local-port injection transmitter for the age-based BLESS bufferless router.
- Accepts packets from the core side into a small FIFO.
- Drives the router's injection port (port4_ci/port4_di) using the router's two-cycle flit format: control word in cycle N, data word in cycle N+1.
- Respects the router's port4_ready and stamps each packet with an age equal to the cycles it spent blocked at the FIFO head.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- AW, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core offers a packet.
- req_ready  out  1  FIFO not full; the packet is accepted when req_valid && req_ready at the edge.
- req_dest  in  4  destination node.
- req_tag  in  16  source/sequence tag.
- req_data  in  128  payload.
- inj_ready  in  1  router port4_ready; high means the injection slot is free this cycle.
- inj_c  out  28 (`control_w)  to router port4_ci.
- inj_d  out  128 (`data_w)  to router port4_di.

Behaviour:
- Control word format: [27] valid, [26:20] age, [19:16] dest, [15:0] tag. Example: 28'h8010001 = valid, age 0, dest 1, tag 1.
- Reset: inj_c=0, inj_d=0, FIFO empty, req_ready=1, head age=0. Reset mid-packet drops the pending data phase; inj_d=0 on the next cycle.
- FIFO: circular buffer with AW-bit read/write pointers plus an AW+1-bit count.
  - Push on req_valid && req_ready.
  - Pop on launch.
  - Simultaneous push and pop leaves count unchanged and is legal when full; req_ready is combinational !full and does not account for a same-cycle pop.
  - Pointers wrap mod DEPTH.
- Launch condition at an edge: FIFO non-empty && inj_ready.
  - The edge registers inj_c = {1'b1, age, dest, tag} of the head.
  - It captures the head's data into a one-entry data stage.
  - It pops the FIFO.
- Data phase: the edge after a launch registers inj_d = captured data. Otherwise inj_d = 0.
- Control phase: inj_c = 0 on any edge without a launch.
- Pipelining: launch of packet k+1 may coincide with the data phase of packet k. Back-to-back launches give a sustained 1 packet/cycle.
- Age: a 7-bit head counter.
  - Increments on each edge where FIFO is non-empty and !inj_ready.
  - Saturates at 7'h7F.
  - Clears to 0 on launch.
  - An entry arriving into an empty FIFO starts at age 0.
- Empty FIFO with inj_ready=1: no launch; outputs are 0.
- Latency: a packet pushed into an empty FIFO at edge E with inj_ready high launches at E+1 (inj_c valid after E+1) and has data after E+2.

Optional Feature:
- Macro: BLESS_INJ_STATS_EN.
- Defined: adds outputs stat_pkts (32, launches) and stat_stall (32, cycles with FIFO non-empty && !inj_ready). Both clear on rst and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- defines.v (shared) holds:
  - `control_w and `data_w;
  - field position constants CTL_VALID=27, CTL_AGE=26:20, CTL_DEST=19:16, CTL_TAG=15:0;
  - AGE_MAX=7'h7F.
- One sub-module is natural: bless_inj_fifo (parameterised DEPTH, 148-bit entries {dest,tag,data}, push/pop/full/empty). bless_inject contains the launch logic, age counter and output registers.

Test Plan:
- Single packet, inj_ready=1: push dest 1, tag 1, data 128'h0123456789abcdef0123456789abcdef -> next cycle inj_c=28'h8010001, following cycle inj_d=that data, then both 0.
- Blocked head: push dest 4, tag 2, hold inj_ready=0 for 5 cycles then 1 -> inj_c=28'h8540002 (age 5), data one cycle later.
- Saturation: inj_ready=0 for 200 cycles -> launched age field = 7'h7F.
- Back-to-back: push tags 1, 2, 3 (dests 1, 4, 6) with inj_ready=1 -> inj_c=8010001, 8040002, 8060003 on consecutive cycles; inj_d of each packet lags by one cycle, overlapping the next control word.
- Full FIFO: 4 pushes with inj_ready=0 -> req_ready=0. A 5th offer is not accepted. Simultaneous push+pop when full keeps count=4. Tag order is preserved across pointer wrap.
- Reset mid-operation: assert rst in the cycle after a launch -> inj_d=0 and inj_c=0 next cycle, req_ready=1, and (with BLESS_INJ_STATS_EN) stat_pkts=0.

Source files
------------

// File: rtl/bless_inject_pkg.sv
// Shared types and constants for the BLESS local-port injection transmitter.
// Control word layout: [27] valid, [26:20] age, [19:16] dest, [15:0] tag.
package bless_inject_pkg;

  localparam int CONTROL_W = 28;
  localparam int DATA_W    = 128;
  localparam int DEST_W    = 4;
  localparam int TAG_W     = 16;
  localparam int AGE_W     = 7;

  localparam int CTL_VALID   = 27;
  localparam int CTL_AGE_HI  = 26;
  localparam int CTL_AGE_LO  = 20;
  localparam int CTL_DEST_HI = 19;
  localparam int CTL_DEST_LO = 16;
  localparam int CTL_TAG_HI  = 15;
  localparam int CTL_TAG_LO  = 0;

  localparam logic [AGE_W-1:0] AGE_MAX = 7'h7F;

  // One FIFO entry: 4 + 16 + 128 = 148 bits.
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } pkt_t;

  // Assemble a valid control word for the router's port4_ci.
  function automatic logic [CONTROL_W-1:0] make_ctl(input logic [AGE_W-1:0]  age,
                                                    input logic [DEST_W-1:0] dest,
                                                    input logic [TAG_W-1:0]  tag);
    logic [CONTROL_W-1:0] ctl;
    ctl                          = '0;
    ctl[CTL_VALID]               = 1'b1;
    ctl[CTL_AGE_HI:CTL_AGE_LO]   = age;
    ctl[CTL_DEST_HI:CTL_DEST_LO] = dest;
    ctl[CTL_TAG_HI:CTL_TAG_LO]   = tag;
    return ctl;
  endfunction

endpackage

// File: rtl/bless_inject_if.sv
// Core-side request bus and router injection port of the BLESS injector.
// master: core/router side that drives requests and inj_ready.
// slave:  the injector itself.
interface bless_inject_if;
  import bless_inject_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [DEST_W-1:0]    req_dest;
  logic [TAG_W-1:0]     req_tag;
  logic [DATA_W-1:0]    req_data;
  logic                 inj_ready;
  logic [CONTROL_W-1:0] inj_c;
  logic [DATA_W-1:0]    inj_d;

  modport master (
    output req_valid, req_dest, req_tag, req_data, inj_ready,
    input  req_ready, inj_c, inj_d
  );

  modport slave (
    input  req_valid, req_dest, req_tag, req_data, inj_ready,
    output req_ready, inj_c, inj_d
  );

endinterface

// File: rtl/bless_inj_fifo.sv
// Circular packet FIFO for the BLESS injector: AW-bit read/write pointers
// wrapping mod DEPTH plus an AW+1-bit occupancy count. A push while full is
// accepted only when a pop happens on the same edge.
module bless_inj_fifo
  import bless_inject_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  pkt_t wdata_i,
  output pkt_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  pkt_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and count values.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count guarantees stale entries are never read as valid.
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bless_inject.sv
// BLESS local-port injection transmitter. Buffers core packets in a FIFO and
// drives the router injection port with a control word on the launch edge and
// the data word on the following edge; the head packet's age counts the
// cycles it waited for inj_ready.
// Optional: define BLESS_INJ_STATS_EN to add stat_pkts/stat_stall counters.
module bless_inject
  import bless_inject_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  bless_inject_if.slave       bus
`ifdef BLESS_INJ_STATS_EN
  ,
  output logic [31:0]         stat_pkts,
  output logic [31:0]         stat_stall
`endif
);

  pkt_t                 wr_pkt, head;
  logic                 fifo_full, fifo_empty;
  logic                 push, launch, stall;
  logic [AGE_W-1:0]     age_q, age_d;
  logic [CONTROL_W-1:0] inj_c_q, inj_c_d;
  logic [DATA_W-1:0]    inj_d_q, inj_d_d;
  logic [DATA_W-1:0]    dstage_q, dstage_d;
  logic                 dvalid_q, dvalid_d;

  assign wr_pkt        = {bus.req_dest, bus.req_tag, bus.req_data};
  assign bus.req_ready = !fifo_full;
  assign push          = bus.req_valid && !fifo_full;
  assign launch        = !fifo_empty && bus.inj_ready;
  assign stall         = !fifo_empty && !bus.inj_ready;
  assign bus.inj_c     = inj_c_q;
  assign bus.inj_d     = inj_d_q;

  bless_inj_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (launch),
    .wdata_i (wr_pkt),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Launch, age and two-phase output next-state logic.
  always_comb begin
    age_d    = age_q;
    inj_c_d  = '0;
    dstage_d = dstage_q;
    dvalid_d = launch;
    inj_d_d  = dvalid_q ? dstage_q : '0;
    if (launch) begin
      age_d    = '0;
      inj_c_d  = make_ctl(age_q, head.dest, head.tag);
      dstage_d = head.data;
    end else if (stall && (age_q != AGE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Output, data-stage and age registers; reset drops any pending data phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q    <= '0;
      inj_c_q  <= '0;
      inj_d_q  <= '0;
      dstage_q <= '0;
      dvalid_q <= 1'b0;
    end else begin
      age_q    <= age_d;
      inj_c_q  <= inj_c_d;
      inj_d_q  <= inj_d_d;
      dstage_q <= dstage_d;
      dvalid_q <= dvalid_d;
    end
  end

`ifdef BLESS_INJ_STATS_EN
  logic [31:0] stat_pkts_q, stat_stall_q;

  assign stat_pkts  = stat_pkts_q;
  assign stat_stall = stat_stall_q;

  // Launch and stall counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (launch) stat_pkts_q  <= stat_pkts_q + 32'd1;
      if (stall)  stat_stall_q <= stat_stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bless_inject.sv
// Scoreboard bench for bless_inject: directed pushes queue hand-computed
// control/data words; a negedge monitor compares every router-side output.
module tb_bless_inject;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bless_inject_if bus ();

`ifdef BLESS_INJ_STATS_EN
  logic [31:0] stat_pkts, stat_stall;
`endif

  bless_inject #(.DEPTH(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef BLESS_INJ_STATS_EN
    ,
    .stat_pkts  (stat_pkts),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct {
    logic [27:0]  ctl;
    logic [127:0] data;
    int           cyc;   // expected launch cycle, -1 = not timed
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every cycle out of reset, compare inj_c against the queue head
  // and inj_d against the data owed by the previous launch (or zero).
  logic         data_pend = 1'b0;
  logic [127:0] data_exp  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      data_pend = 1'b0;
    end else begin
      if (data_pend) check("inj_d", bus.inj_d, data_exp);
      else           check("inj_d_idle", bus.inj_d, 128'd0);
      data_pend = 1'b0;
      if (bus.inj_c != 28'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_launch", {100'd0, bus.inj_c}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("inj_c", {100'd0, bus.inj_c}, {100'd0, e.ctl});
          if (e.cyc >= 0) check("launch_cycle", 128'(cyc), 128'(e.cyc));
          data_pend = 1'b1;
          data_exp  = e.data;
        end
      end
    end
  end

  task automatic push_pkt(input logic [3:0] d, input logic [15:0] t, input logic [127:0] dat,
                          output bit acc, output int pcyc);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_dest  = d;
    bus.req_tag   = t;
    bus.req_data  = dat;
    #1 acc = bus.req_ready;
    @(posedge clk);
    #1;
    pcyc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_pkt(input logic [27:0] ctl, input logic [127:0] dat, input int lc);
    exp_t e;
    e.ctl  = ctl;
    e.data = dat;
    e.cyc  = lc;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int p;
    int tries;

    bus.req_valid = 1'b0;
    bus.req_dest  = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    bus.inj_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_inj_c", {100'd0, bus.inj_c}, 128'd0);
    check("rst_inj_d", bus.inj_d, 128'd0);
    check("rst_req_ready", {127'd0, bus.req_ready}, 128'd1);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single packet, inj_ready high.
    push_pkt(4'd1, 16'h0001, 128'h0123456789abcdef0123456789abcdef, acc, p);
    check("single_acc", {127'd0, acc}, 128'd1);
    expect_pkt(28'h8010001, 128'h0123456789abcdef0123456789abcdef, p + 1);
    repeat (4) @(negedge clk);

    // Blocked head: five stall cycles -> age 5.
    bus.inj_ready = 1'b0;
    push_pkt(4'd4, 16'h0002, 128'hfeedface_00000002_cafef00d_12345678, acc, p);
    expect_pkt(28'h8540002, 128'hfeedface_00000002_cafef00d_12345678, p + 6);
    repeat (6) @(negedge clk);
    bus.inj_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Saturation: 200 stall cycles -> age 7F.
    bus.inj_ready = 1'b0;
    push_pkt(4'd3, 16'h00AA, 128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa, acc, p);
    expect_pkt(28'hFF300AA, 128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa, p + 201);
    repeat (201) @(negedge clk);
    bus.inj_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back launches at one packet per cycle.
    push_pkt(4'd1, 16'h0001, 128'h11111111_11111111_11111111_11111111, acc, p);
    expect_pkt(28'h8010001, 128'h11111111_11111111_11111111_11111111, p + 1);
    push_pkt(4'd4, 16'h0002, 128'h22222222_22222222_22222222_22222222, acc, p);
    expect_pkt(28'h8040002, 128'h22222222_22222222_22222222_22222222, p + 1);
    push_pkt(4'd6, 16'h0003, 128'h33333333_33333333_33333333_33333333, acc, p);
    expect_pkt(28'h8060003, 128'h33333333_33333333_33333333_33333333, p + 1);
    repeat (4) @(negedge clk);

    // Full FIFO, rejected offer, order across pointer wrap.
    bus.inj_ready = 1'b0;
    push_pkt(4'd7, 16'h0010, 128'h10, acc, p);
    expect_pkt(28'h8470010, 128'h10, p + 5);
    push_pkt(4'd8, 16'h0011, 128'h11, acc, p);
    expect_pkt(28'h8080011, 128'h11, -1);
    push_pkt(4'd9, 16'h0012, 128'h12, acc, p);
    expect_pkt(28'h8090012, 128'h12, -1);
    push_pkt(4'hA, 16'h0013, 128'h13, acc, p);
    expect_pkt(28'h80A0013, 128'h13, -1);
    check("full_req_ready", {127'd0, bus.req_ready}, 128'd0);
    push_pkt(4'hB, 16'h0014, 128'h14, acc, p);
    check("full_5th_rejected", {127'd0, acc}, 128'd0);
    bus.inj_ready = 1'b1;
    tries = 0;
    do begin
      push_pkt(4'hB, 16'h0014, 128'h14, acc, p);
      tries++;
    end while (!acc && tries < 4);
    check("full_pop_then_accept_tries", 128'(tries), 128'd2);
    expect_pkt(28'h80B0014, 128'h14, -1);
    repeat (8) @(negedge clk);

    // Reset in the cycle after a launch.
    push_pkt(4'd2, 16'h0055, 128'hdeadbeef_deadbeef_deadbeef_deadbeef, acc, p);
    expect_pkt(28'h8020055, 128'hdeadbeef_deadbeef_deadbeef_deadbeef, p + 1);
    @(negedge clk);
    @(negedge clk);
`ifdef BLESS_INJ_STATS_EN
    #1;
    check("stat_pkts", 128'(stat_pkts), 128'd12);
    check("stat_stall", 128'(stat_stall), 128'd209);
`endif
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_inj_c", {100'd0, bus.inj_c}, 128'd0);
    check("midrst_inj_d", bus.inj_d, 128'd0);
    check("midrst_req_ready", {127'd0, bus.req_ready}, 128'd1);
`ifdef BLESS_INJ_STATS_EN
    check("midrst_stat_pkts", 128'(stat_pkts), 128'd0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
